// File: rtl/pb_debounce_scheduler_pkg.sv
// Shared types and defaults for the push-button debounce scheduler.
// One stability timer is time-shared across all buttons by a round-robin grant.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        COMMIT
    } pb_sched_state_t;

    localparam int PB_DEFAULT_N     = 4;
    localparam int PB_DEFAULT_DELAY = 15;

endpackage

// File: rtl/pb_debounce_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Candidate indices are rotated by ptr so the lowest rotated slot wins.
module pb_rr_picker #(
    parameter int N_PB = 4
) (
    input  logic [N_PB-1:0]         req,
    input  logic [$clog2(N_PB)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(N_PB)-1:0] idx
);
    localparam int IW = $clog2(N_PB);
    localparam int SW = IW + 1;

    logic [IW-1:0] cand [N_PB];

    for (genvar gi = 0; gi < N_PB; gi++) begin : g_cand
        logic [SW-1:0] sum;
        assign sum       = {1'b0, ptr} + SW'(gi);
        assign cand[gi]  = (sum >= SW'(N_PB)) ? IW'(sum - SW'(N_PB)) : sum[IW-1:0];
    end

    // Walk from the farthest slot back to ptr so the nearest request is the last assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N_PB - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/pb_debounce_scheduler.sv
// Debounces N_PB buttons with a single shared stability timer granted round-robin
// to whichever button's synchronized level disagrees with its debounced level.
module pb_debounce_scheduler
    import pb_pkg::*;
#(
    parameter int N_PB  = PB_DEFAULT_N,
    parameter int DELAY = PB_DEFAULT_DELAY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_PB-1:0]         pb,
    output logic [N_PB-1:0]         pb_status,
    output logic [N_PB-1:0]         pb_pressed_pulse,
    output logic [N_PB-1:0]         pb_released_pulse,
    output logic                    busy,
    output logic [$clog2(N_PB)-1:0] active_ch
);
    localparam int CW = $clog2(N_PB);
    localparam int TW = $clog2(DELAY);
    localparam logic [TW-1:0] T_LAST  = TW'(DELAY - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(N_PB - 1);

    logic [N_PB-1:0] sync_aux_q;
    logic [N_PB-1:0] sync_q;
    logic [N_PB-1:0] status_q, status_d;
    pb_sched_state_t state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   ch_q, ch_d;

    logic [N_PB-1:0] mismatch;
    logic            pick_valid;
    logic [CW-1:0]   pick_idx;
    logic [CW-1:0]   ch_inc;

    for (genvar gi = 0; gi < N_PB; gi++) begin : g_mismatch
        assign mismatch[gi] = sync_q[gi] ^ status_q[gi];
    end

    pb_rr_picker #(
        .N_PB (N_PB)
    ) u_picker (
        .req   (mismatch),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign ch_inc = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_aux_q <= '0;
            sync_q     <= '0;
            status_q   <= '0;
            state_q    <= IDLE;
            timer_q    <= '0;
            ptr_q      <= '0;
            ch_q       <= '0;
        end else begin
            sync_aux_q <= pb;
            sync_q     <= sync_aux_q;
            status_q   <= status_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            ptr_q      <= ptr_d;
            ch_q       <= ch_d;
        end
    end

    // ch_q is forced back to 0 whenever the grant is released so active_ch reads 0 in IDLE.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ptr_d    = ptr_q;
        ch_d     = ch_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    ch_d    = pick_idx;
                    timer_d = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!mismatch[ch_q]) begin
                    ptr_d   = ch_inc;
                    ch_d    = '0;
                    state_d = IDLE;
                end else if (timer_q == T_LAST) begin
                    state_d = COMMIT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COMMIT: begin
                status_d[ch_q] = ~status_q[ch_q];
                ptr_d          = ch_inc;
                ch_d           = '0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < N_PB; gi++) begin : g_pulse
        logic sel;
        assign sel                   = (state_q == COMMIT) && (ch_q == CW'(gi));
        assign pb_pressed_pulse[gi]  = sel && !status_q[gi];
        assign pb_released_pulse[gi] = sel &&  status_q[gi];
    end

    assign pb_status = status_q;
    assign busy      = (state_q != IDLE);
    assign active_ch = ch_q;

endmodule

// File: tb/tb_pb_debounce_scheduler.sv
// Self-checking bench for pb_debounce_scheduler (N_PB=4, DELAY=4) against a
// button-level reference model of the shared-timer round-robin debouncer.
module tb_pb_debounce_scheduler;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(N);
    localparam int VW = 3 * N + 1 + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  pb  = '0;
    logic [N-1:0]  pb_status, pb_pressed_pulse, pb_released_pulse;
    logic          busy;
    logic [CW-1:0] active_ch;
    logic [VW-1:0] act;

    int checks   = 0;
    int failures = 0;

    pb_debounce_scheduler #(.N_PB(N), .DELAY(D)) dut (
        .clk               (clk),
        .rst               (rst),
        .pb                (pb),
        .pb_status         (pb_status),
        .pb_pressed_pulse  (pb_pressed_pulse),
        .pb_released_pulse (pb_released_pulse),
        .busy              (busy),
        .active_ch         (active_ch)
    );

    always #5 clk = ~clk;

    assign act = {pb_status, pb_pressed_pulse, pb_released_pulse, busy, active_ch};

    // Reference model: two-sample view of raw buttons, debounced levels, and the
    // single owner of the timer with how many confirming samples it has seen.
    bit [N-1:0] m_s1, m_s2, m_status;
    int         m_owner, m_age, m_ptr;
    bit         m_commit;

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_status = '0;
        m_owner = -1; m_age = 0; m_ptr = 0; m_commit = 1'b0;
    endfunction

    function automatic void model_edge(input bit [N-1:0] raw);
        bit [N-1:0] want;
        want = m_s2 ^ m_status;
        if (m_commit) begin
            m_status[m_owner] = ~m_status[m_owner];
            m_ptr    = (m_owner + 1) % N;
            m_owner  = -1;
            m_commit = 1'b0;
        end else if (m_owner >= 0) begin
            if (!want[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_age++;
                if (m_age == D) m_commit = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (want[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_age   = 0;
                    break;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0]  pr, rl;
        logic [CW-1:0] ch;
        logic          b;
        pr = '0; rl = '0; ch = '0;
        b  = (m_owner >= 0);
        if (m_commit) begin
            if (m_status[m_owner]) rl[m_owner] = 1'b1;
            else                   pr[m_owner] = 1'b1;
        end
        if (b) ch = CW'(m_owner);
        return {m_status, pr, rl, b, ch};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge(pb);
        else     model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        pb = 4'($urandom);
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (act !== '0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d act=%h exp=0", n, act);
            end
        end
        pb = '0;
        rst = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        $display("test_reset done");
    endtask

    task automatic test_edge(input bit level, input string name);
        int pulse_at, status_at;
        pulse_at = -1; status_at = -1;
        pb[1] = level;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL %s_model cyc=%0d act=%h exp=%h", name, n, act, exp_vec());
            end
            checks++;
            if (busy !== (n >= 2 && n <= 2 + D)) begin
                failures++;
                $display("FAIL %s_busy cyc=%0d act=%b exp=%b", name, n, busy, (n >= 2 && n <= 2 + D));
            end
            if ((level ? pb_pressed_pulse[1] : pb_released_pulse[1]) && pulse_at < 0) pulse_at = n;
            if (pb_status[1] === level && status_at < 0) status_at = n;
        end
        checks++;
        if (pulse_at != 2 + D) begin
            failures++;
            $display("FAIL %s_pulse_time act=%0d exp=%0d", name, pulse_at, 2 + D);
        end
        checks++;
        if (status_at != 3 + D) begin
            failures++;
            $display("FAIL %s_status_time act=%0d exp=%0d", name, status_at, 3 + D);
        end
        $display("test_%s done", name);
    endtask

    task automatic test_bounce();
        bit any_pulse;
        int first_ch;
        any_pulse = 1'b0; first_ch = -1;
        pb[2] = 1'b1;
        tick(); tick();
        pb[2] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d act=%h exp=%h", n, act, exp_vec());
            end
            if (|(pb_pressed_pulse | pb_released_pulse)) any_pulse = 1'b1;
        end
        checks++;
        if (any_pulse || busy !== 1'b0 || pb_status !== 4'b0000) begin
            failures++;
            $display("FAIL bounce_quiet pulse=%b busy=%b status=%b exp pulse=0 busy=0 status=0000",
                     any_pulse, busy, pb_status);
        end
        // Pointer should now sit at 3: of pb[1] and pb[3], pb[3] wins first.
        pb[1] = 1'b1; pb[3] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL bounce_ptr_model cyc=%0d act=%h exp=%h", n, act, exp_vec());
            end
            if (busy && first_ch < 0) first_ch = int'(active_ch);
        end
        checks++;
        if (first_ch != 3) begin
            failures++;
            $display("FAIL bounce_rr_ptr act=%0d exp=3", first_ch);
        end
        pb = '0;
        for (int n = 0; n < 20; n++) tick();
        $display("test_bounce done");
    endtask

    task automatic test_simultaneous();
        int t0, t3;
        t0 = -1; t3 = -1;
        rst = 1'b0; pb = '0;
        model_reset();
        tick(); tick();
        rst = 1'b1;
        pb[0] = 1'b1; pb[3] = 1'b1;
        for (int n = 0; n < 18; n++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL simul_model cyc=%0d act=%h exp=%h", n, act, exp_vec());
            end
            if (pb_pressed_pulse[0] && t0 < 0) t0 = n;
            if (pb_pressed_pulse[3] && t3 < 0) t3 = n;
        end
        checks++;
        if (t0 != 2 + D || t3 != 2 + D + (D + 2)) begin
            failures++;
            $display("FAIL simul_order t0=%0d t3=%0d exp t0=%0d t3=%0d", t0, t3, 2 + D, 2 * D + 4);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_chatter();
        int t2;
        t2 = -1;
        pb[2] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            pb[1] = ~pb[1];
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL chatter_model cyc=%0d act=%h exp=%h", n, act, exp_vec());
            end
            if (pb_pressed_pulse[2] && t2 < 0) t2 = n;
        end
        checks++;
        if (t2 < 0 || t2 > 2 * (D + 2) + 3) begin
            failures++;
            $display("FAIL chatter_starve act=%0d exp<=%0d", t2, 2 * (D + 2) + 3);
        end
        pb[1] = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        $display("test_chatter done");
    endtask

    task automatic test_reset_mid_count();
        int t0;
        t0 = -1;
        rst = 1'b0; pb = '0;
        model_reset();
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        pb[0] = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (busy !== 1'b1 || active_ch !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_precount busy=%b ch=%0d exp busy=1 ch=0", busy, active_ch);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL rstmid_async act=%h exp=0", act);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_model cyc=%0d act=%h exp=%h", n, act, exp_vec());
            end
            if (pb_pressed_pulse[0] && t0 < 0) t0 = n;
        end
        checks++;
        if (t0 != 2 + D) begin
            failures++;
            $display("FAIL rstmid_pulse_time act=%0d exp=%0d", t0, 2 + D);
        end
        $display("test_reset_mid_count done");
    endtask

    task automatic test_random();
        int hold [N];
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 2 * D + 3);
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    pb[i]   = ~pb[i];
                    hold[i] = $urandom_range(1, 2 * D + 3);
                end
            end
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL random_model cyc=%0d act=%h exp=%h", n, act, exp_vec());
            end
            checks++;
            if ($countones({pb_pressed_pulse, pb_released_pulse}) > 1) begin
                failures++;
                $display("FAIL random_onehot cyc=%0d act=%b_%b exp=at most one bit", n,
                         pb_pressed_pulse, pb_released_pulse);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_edge(1'b1, "clean_press");
        test_edge(1'b0, "clean_release");
        test_bounce();
        test_simultaneous();
        test_chatter();
        test_reset_mid_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
